// File: rtl/lcd_pkg.sv
// Shared types, wdata field map, time-to-cycle helpers and the power-on init ROM
// for the LCD command driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC,
    ST_INIT_WAIT
  } state_t;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned WD_RS      = 8;
  localparam int unsigned WD_RW      = 9;
  localparam int unsigned WD_CLR_OVR = 30;
  localparam int unsigned WD_ON      = 31;

`ifdef LCD_INIT_SEQ_EN
  localparam int unsigned INIT_LEN = 6;
  localparam logic [DATA_W-1:0] INIT_ROM [INIT_LEN] =
    '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
`endif

  // Round up so every interval is at least as long as the LCD datasheet asks for.
  function automatic longint unsigned ns_to_cycles(input longint unsigned t_ns,
                                                   input longint unsigned hz);
    return (t_ns * hz + 64'd999_999_999) / 64'd1_000_000_000;
  endfunction

  function automatic longint unsigned us_to_cycles(input longint unsigned t_us,
                                                   input longint unsigned hz);
    return (t_us * hz + 64'd999_999) / 64'd1_000_000;
  endfunction

  // Clear display / return home need the long execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [DATA_W-1:0] d);
    return !rs && (d[7:2] == 6'd0) && (d[1:0] != 2'd0);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter for the bus/exec phase timing; holds at zero, done while zero.
module lcd_timer #(
  parameter int unsigned W       = 17,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= W'(RST_VAL);
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/lcd_cmd_driver.sv
// Turns LSU stores to the LCD register into timed HD44780 write cycles with a one-entry
// pending buffer. Define LCD_INIT_SEQ_EN to run the power-on init sequence after reset.
module lcd_cmd_driver
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned T_SETUP_NS  = 40,
  parameter int unsigned T_PULSE_NS  = 240,
  parameter int unsigned T_HOLD_NS   = 20,
  parameter int unsigned T_SHORT_US  = 40,
  parameter int unsigned T_LONG_US   = 1640
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lcd_we,
  input  logic [31:0] i_lcd_wdata,
  output logic        o_lcd_busy,
  output logic        o_lcd_ovr,
  output logic        o_lcd_on,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data
);

  localparam longint unsigned HZ = 64'(CLK_FREQ_HZ);
  localparam int unsigned SETUP_CYC = 32'(ns_to_cycles(64'(T_SETUP_NS), HZ));
  localparam int unsigned PULSE_CYC = 32'(ns_to_cycles(64'(T_PULSE_NS), HZ));
  localparam int unsigned HOLD_CYC  = 32'(ns_to_cycles(64'(T_HOLD_NS), HZ));
  localparam int unsigned SHORT_CYC = 32'(us_to_cycles(64'(T_SHORT_US), HZ));
  localparam int unsigned LONG_CYC  = 32'(us_to_cycles(64'(T_LONG_US), HZ));

`ifdef LCD_INIT_SEQ_EN
  localparam int unsigned INIT_WAIT_CYC  = 32'(us_to_cycles(64'd15_000, HZ));
  localparam int unsigned INIT_FIRST_CYC = 32'(us_to_cycles(64'd4_100, HZ));
  localparam int unsigned MAX_A   = (INIT_WAIT_CYC > LONG_CYC) ? INIT_WAIT_CYC : LONG_CYC;
  localparam int unsigned MAX_CYC = (INIT_FIRST_CYC > MAX_A) ? INIT_FIRST_CYC : MAX_A;
  localparam int unsigned TMR_RST = INIT_WAIT_CYC - 1;
  localparam state_t      RST_STATE = ST_INIT_WAIT;
  localparam logic        ON_RST    = 1'b1;
`else
  localparam int unsigned MAX_CYC = LONG_CYC;
  localparam int unsigned TMR_RST = 0;
  localparam state_t      RST_STATE = ST_IDLE;
  localparam logic        ON_RST    = 1'b0;
`endif
  localparam int unsigned TMR_W = $clog2(MAX_CYC + 1);

  state_t            state_q, state_d;
  logic              tmr_load, tmr_done;
  logic [TMR_W-1:0]  tmr_val, exec_val;
  logic              launch, launch_rs, pend_pop;
  logic [7:0]        launch_data;
  logic              pend_valid_q, pend_rs_q;
  logic [7:0]        pend_data_q;
  logic              rs_q, en_q, on_q, ovr_q;
  logic [7:0]        data_q;
  logic              store, drop;
  logic              unused_wdata;

`ifdef LCD_INIT_SEQ_EN
  logic              init_active_q, init_step, init_end;
  logic [2:0]        init_idx_q;
`endif

  // A write is buffered only when the bus is occupied; a full buffer drops it.
  assign store = i_lcd_we && !pend_valid_q && (state_q != ST_IDLE);
  assign drop  = i_lcd_we && pend_valid_q;
  assign unused_wdata = ^{i_lcd_wdata[29:10], i_lcd_wdata[WD_RW]};

  lcd_timer #(
    .W       (TMR_W),
    .RST_VAL (TMR_RST)
  ) u_timer (
    .clk   (i_clk),
    .rst_n (i_reset),
    .load  (tmr_load),
    .value (tmr_val),
    .done  (tmr_done)
  );

  // Exec wait is chosen from the pins, which hold the command currently on the bus.
  always_comb begin
    exec_val = is_long_cmd(rs_q, data_q) ? TMR_W'(LONG_CYC - 1) : TMR_W'(SHORT_CYC - 1);
`ifdef LCD_INIT_SEQ_EN
    if (init_active_q && (init_idx_q == 3'd1)) exec_val = TMR_W'(INIT_FIRST_CYC - 1);
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= RST_STATE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    launch      = 1'b0;
    launch_rs   = 1'b0;
    launch_data = 8'h00;
    pend_pop    = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    init_step   = 1'b0;
    init_end    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          launch      = 1'b1;
          launch_rs   = pend_rs_q;
          launch_data = pend_data_q;
          pend_pop    = 1'b1;
        end else if (i_lcd_we) begin
          launch      = 1'b1;
          launch_rs   = i_lcd_wdata[WD_RS];
          launch_data = i_lcd_wdata[7:0];
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(PULSE_CYC - 1);
        end
      end
      ST_PULSE: begin
        if (tmr_done) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(HOLD_CYC - 1);
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          state_d  = ST_EXEC;
          tmr_load = 1'b1;
          tmr_val  = exec_val;
        end
      end
      ST_EXEC: begin
        if (tmr_done) begin
`ifdef LCD_INIT_SEQ_EN
          init_end = init_active_q && (init_idx_q == 3'(INIT_LEN));
          if (init_active_q && !init_end) begin
            launch      = 1'b1;
            launch_data = INIT_ROM[init_idx_q];
            init_step   = 1'b1;
          end else
`endif
          if (pend_valid_q) begin
            launch      = 1'b1;
            launch_rs   = pend_rs_q;
            launch_data = pend_data_q;
            pend_pop    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
`ifdef LCD_INIT_SEQ_EN
      ST_INIT_WAIT: begin
        if (tmr_done) begin
          launch      = 1'b1;
          launch_data = INIT_ROM[0];
          init_step   = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Every launch enters SETUP straight away, from IDLE, EXEC or INIT_WAIT alike.
    if (launch) begin
      state_d  = ST_SETUP;
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(SETUP_CYC - 1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
      en_q         <= 1'b0;
      on_q         <= ON_RST;
      ovr_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_rs_q    <= 1'b0;
      pend_data_q  <= 8'h00;
    end else begin
      en_q <= (state_d == ST_PULSE);
      if (launch) begin
        rs_q   <= launch_rs;
        data_q <= launch_data;
      end
      if (pend_pop) pend_valid_q <= 1'b0;
      if (store) begin
        pend_valid_q <= 1'b1;
        pend_rs_q    <= i_lcd_wdata[WD_RS];
        pend_data_q  <= i_lcd_wdata[7:0];
      end
      if (i_lcd_we) on_q <= i_lcd_wdata[WD_ON];
      // A drop outranks a clear request carried by the same write.
      if (drop)                                    ovr_q <= 1'b1;
      else if (i_lcd_we && i_lcd_wdata[WD_CLR_OVR]) ovr_q <= 1'b0;
    end
  end

`ifdef LCD_INIT_SEQ_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      init_active_q <= 1'b1;
      init_idx_q    <= 3'd0;
    end else begin
      if (init_step) init_idx_q <= init_idx_q + 3'd1;
      if (init_end)  init_active_q <= 1'b0;
    end
  end
`endif

  assign o_lcd_busy = (state_q != ST_IDLE) | pend_valid_q;
  assign o_lcd_ovr  = ovr_q;
  assign o_lcd_on   = on_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_data = data_q;

endmodule

// File: tb/tb_lcd_cmd_driver.sv
// Bench for lcd_cmd_driver: vector table plus hand sequences for buffering, overrun and reset.
module tb_lcd_cmd_driver;

  typedef struct {
    logic [31:0] wdata;
    logic        rs;
    logic [7:0]  data;
    logic        on;
    int unsigned busy_len;   // 0: abort with reset once the strobe has been seen
  } vec_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [31:0] wdata;
  logic        busy, ovr, on, rs, rw, en;
  logic [7:0]  data;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  exp_t        exp_q[$];
  vec_t        vecs[5];

  always #5 clk = ~clk;

  lcd_cmd_driver dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_lcd_we    (we),
    .i_lcd_wdata (wdata),
    .o_lcd_busy  (busy),
    .o_lcd_ovr   (ovr),
    .o_lcd_on    (on),
    .o_lcd_rs    (rs),
    .o_lcd_rw    (rw),
    .o_lcd_en    (en),
    .o_lcd_data  (data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic r, input logic [7:0] d);
    exp_t e;
    e.rs   = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] w);
    wdata = w;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Watches up to 'limit' cycles; scoreboard entries are checked at each EN rise.
  task automatic measure(input int unsigned limit, output int unsigned fr, output int unsigned lr,
                         output int unsigned rc, output int unsigned el, output int unsigned bl,
                         output logic rs1, output logic [7:0] d1);
    logic prev;
    exp_t e;
    prev = 1'b0;
    fr = 0; lr = 0; rc = 0; el = 0; bl = 0; rs1 = 1'b0; d1 = 8'h00;
    for (int unsigned k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rs1 = rs;
        d1  = data;
      end
      if (en) begin
        el++;
        if (!prev) begin
          rc++;
          if (fr == 0) fr = k;
          lr = k;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_unexpected_en: strobe with data 0x%0h, want no strobe", data);
          end else begin
            e = exp_q.pop_front();
            chk("sb_rs", 32'(rs), 32'(e.rs));
            chk("sb_data", 32'(data), 32'(e.data));
          end
        end
      end
      prev = en;
      if (!busy) begin
        bl = k - 1;
        break;
      end
    end
  endtask

  initial begin
    int unsigned fr, lr, rc, el, bl, lim, bad;
    logic        rs1;
    logic [7:0]  d1;

    vecs[0] = '{32'h8000_0141, 1'b1, 8'h41, 1'b1, 2015};
    vecs[1] = '{32'h0000_0001, 1'b0, 8'h01, 1'b0, 82015};
    vecs[2] = '{32'h8000_0302, 1'b1, 8'h02, 1'b1, 2015};
    vecs[3] = '{32'h0000_0038, 1'b0, 8'h38, 1'b0, 0};
    vecs[4] = '{32'h8000_0004, 1'b0, 8'h04, 1'b1, 0};

    rst_n = 1'b0;
    we    = 1'b0;
    wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
`ifdef LCD_INIT_SEQ_EN
    chk("rst_on", 32'(on), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("init_busy", 32'(busy), 32'd1);
    push(1'b0, 8'h38); push(1'b0, 8'h38); push(1'b0, 8'h38);
    push(1'b0, 8'h0C); push(1'b0, 8'h01); push(1'b0, 8'h06);
    measure(1_100_000, fr, lr, rc, el, bl, rs1, d1);
    chk("init_strobes", rc, 32'd6);
    chk("init_first_window", 32'(fr >= 749_995 && fr <= 750_010), 32'd1);
    chk("init_finished", 32'(bl != 0), 32'd1);
`else
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_on", 32'(on), 32'd0);
    chk("rst_rs", 32'(rs), 32'd0);
    chk("rst_rw", 32'(rw), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      push(vecs[i].rs, vecs[i].data);
      wr(vecs[i].wdata);
      chk("on", 32'(on), 32'(vecs[i].on));
      chk("busy_accept", 32'(busy), 32'd1);
      chk("ovr_clear", 32'(ovr), 32'd0);
      lim = (vecs[i].busy_len == 0) ? 20 : vecs[i].busy_len + 5;
      measure(lim, fr, lr, rc, el, bl, rs1, d1);
      chk("pin_rs_next", 32'(rs1), 32'(vecs[i].rs));
      chk("pin_data_next", 32'(d1), 32'(vecs[i].data));
      chk("en_first", fr, 32'd3);
      chk("en_width", el, 32'd12);
      chk("en_count", rc, 32'd1);
      chk("busy_len", bl, vecs[i].busy_len);
      chk("rw", 32'(rw), 32'd0);
      if (vecs[i].busy_len == 0) begin
        chk("rs_stable", 32'(rs), 32'(vecs[i].rs));
        chk("data_stable", 32'(data), 32'(vecs[i].data));
        do_reset();
      end
    end

    // Three back-to-back writes: run, buffer, drop (the dropped one also asks for ovr clear).
    push(1'b1, 8'h41);
    push(1'b1, 8'h42);
    wr(32'h8000_0141);
    wr(32'h8000_0142);
    wr(32'h4000_0143);
    chk("ovr_set_wins", 32'(ovr), 32'd1);
    chk("on_from_dropped", 32'(on), 32'd0);
    chk("busy_b2b", 32'(busy), 32'd1);
    measure(4100, fr, lr, rc, el, bl, rs1, d1);
    chk("b2b_strobes", rc, 32'd2);
    chk("b2b_first_en", fr, 32'd1);
    chk("b2b_second_en", lr, 32'd2016);
    chk("b2b_en_total", el, 32'd24);
    chk("b2b_busy_len", bl, 32'd4028);
    chk("ovr_sticky", 32'(ovr), 32'd1);

    // Clear overrun from idle, buffer one more, then reset asynchronously mid-pulse.
    push(1'b0, 8'h41);
    wr(32'h4000_0041);
    chk("ovr_cleared", 32'(ovr), 32'd0);
    chk("on_clr", 32'(on), 32'd0);
    chk("busy_clr", 32'(busy), 32'd1);
    wr(32'h8000_0055);
    chk("on_pending", 32'(on), 32'd1);
    chk("ovr_pending", 32'(ovr), 32'd0);
    measure(5, fr, lr, rc, el, bl, rs1, d1);
    chk("clr_en_first", fr, 32'd2);
    chk("clr_rs", 32'(rs1), 32'd0);
    chk("clr_data", 32'(d1), 32'h41);
    chk("clr_still_busy", bl, 32'd0);
    chk("in_pulse", 32'(en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_en", 32'(en), 32'd0);
    chk("async_data", 32'(data), 32'd0);
    chk("async_rs", 32'(rs), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_on", 32'(on), 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (en || busy) bad++;
    end
    chk("pending_lost", bad, 32'd0);
`endif
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
